// File: rtl/mux_read_arbiter.sv
// -----------------------------------------------------------------------------
// mux_read_arbiter
//   Round-robin sequencer for a shared 4-input read mux. Each requester asks
//   for one read of its mux input. A single one-hot select is driven for the
//   settle time, then the mux output is captured and the winner is acked.
//   An all-zero select cycle always separates successive grants.
//
// Ports
//   clk    in   1   system clock, rising edge
//   rst_n  in   1   asynchronous active-low reset
//   req    in   4   level requests, req[i] selects mux input i (a..d)
//   mux_o  in   DW  output of the shared read mux
//   sel    out  4   one-hot select to the mux (sel[0]=a_addr .. sel[3]=d_addr)
//   rdata  out  DW  data captured by the last completed transaction
//   ack    out  4   one-cycle pulse to the winner, rdata valid in same cycle
//   busy   out  1   high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module mux_read_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned DW            = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    req,
  input  logic [DW-1:0] mux_o,
  output logic [3:0]    sel,
  output logic [DW-1:0] rdata,
  output logic [3:0]    ack,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

  // Counter is loaded with SETTLE_CYCLES-1 so capture happens on the
  // SETTLE_CYCLES-th edge after the select is asserted.
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [3:0]    sel_q, sel_d;
  logic [3:0]    ack_q, ack_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          busy_q, busy_d;
  logic [1:0]    win_s;

  // First set request bit scanning upward from ptr, wrapping modulo 4.
  function automatic logic [1:0] pick_winner(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic       found;
    pick_winner = p;
    found       = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = p + 2'(i);
      if (!found && r[idx]) begin
        pick_winner = idx;
        found       = 1'b1;
      end
    end
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] g);
    onehot = 4'b0001 << g;
  endfunction

  // Round-robin winner for the current request vector.
  always_comb begin
    win_s = pick_winner(req, ptr_q);
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ack_d   = 4'b0000;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req != 4'b0000) begin
          gnt_d   = win_s;
          sel_d   = onehot(win_s);
          cnt_d   = CNT_INIT;
          state_d = ST_SETTLE;
        end else begin
          sel_d = 4'b0000;
        end
      end
      ST_SETTLE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // A withdrawn request aborts: no ack and rdata is left untouched,
          // but the pointer still advances so the slot is not re-granted first.
          if (req[gnt_q]) begin
            rdata_d = mux_o;
            ack_d   = onehot(gnt_q);
          end else begin
            rdata_d = rdata_q;
          end
          sel_d   = 4'b0000;
          ptr_d   = gnt_q + 2'd1;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        sel_d   = 4'b0000;
        state_d = ST_IDLE;
      end
      default: begin
        sel_d   = 4'b0000;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset clears sel without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      ptr_q   <= 2'd0;
      gnt_q   <= 2'd0;
      sel_q   <= 4'b0000;
      ack_q   <= 4'b0000;
      rdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
    end
  end

  assign sel   = sel_q;
  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mux_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_read_arbiter
//   Two instances: index 0 with SETTLE_CYCLES=1, index 1 with SETTLE_CYCLES=3.
//   A timestamp-based model predicts sel/ack/rdata/busy each cycle; a compare
//   process checks them on every falling edge. Directed sequences add literal
//   expectations that pin the model.
// -----------------------------------------------------------------------------
module tb_mux_read_arbiter;

  localparam logic [7:0] MUXV [4] = '{8'haa, 8'hbb, 8'hcc, 8'hdd};

  logic       clk;
  logic       rst_n;
  logic [3:0] req_s   [2];
  logic [7:0] mux_s   [2];
  logic [3:0] sel_s   [2];
  logic [7:0] rdata_s [2];
  logic [3:0] ack_s   [2];
  logic       busy_s  [2];

  int n_checks;
  int n_pass;

  mux_read_arbiter #(.SETTLE_CYCLES(1), .DW(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req_s[0]), .mux_o(mux_s[0]),
    .sel(sel_s[0]), .rdata(rdata_s[0]), .ack(ack_s[0]), .busy(busy_s[0])
  );

  mux_read_arbiter #(.SETTLE_CYCLES(3), .DW(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req_s[1]), .mux_o(mux_s[1]),
    .sel(sel_s[1]), .rdata(rdata_s[1]), .ack(ack_s[1]), .busy(busy_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared mux: a=aa, b=bb, c=cc, d=dd, zero when nothing selected.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      mux_s[k] = 8'h00;
      for (int i = 0; i < 4; i++)
        if (sel_s[k][i]) mux_s[k] = MUXV[i];
    end
  end

  function automatic int settle_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // ---------------- model: grants as timestamps ----------------
  int         cyc;
  int         gedge [2];
  int         nok   [2];
  int         g     [2];
  int         mptr  [2];
  bit         act   [2];
  logic [3:0] esel  [2];
  logic [3:0] eack  [2];
  logic [7:0] erd   [2];
  logic       ebusy [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0;
      for (int k = 0; k < 2; k++) begin
        act[k] = 0; nok[k] = 0; mptr[k] = 0; g[k] = 0; gedge[k] = 0;
        esel[k] = 4'b0; eack[k] = 4'b0; erd[k] = 8'h00; ebusy[k] = 1'b0;
      end
    end else begin
      cyc = cyc + 1;
      for (int k = 0; k < 2; k++) begin
        eack[k] = 4'b0;
        if (act[k] && cyc == gedge[k] + settle_of(k)) begin
          if (req_s[k][g[k]]) begin
            erd[k]  = MUXV[g[k]];
            eack[k] = 4'(1 << g[k]);
          end
          mptr[k] = (g[k] + 1) % 4;
          act[k]  = 0;
          nok[k]  = cyc + 2;
        end else if (!act[k] && cyc >= nok[k] && req_s[k] != 4'b0) begin
          bit found;
          found = 0;
          for (int j = 0; j < 4; j++) begin
            if (!found && req_s[k][(mptr[k] + j) % 4]) begin
              g[k]  = (mptr[k] + j) % 4;
              found = 1;
            end
          end
          gedge[k] = cyc;
          act[k]   = 1;
        end
        esel[k]  = act[k] ? 4'(1 << g[k]) : 4'b0;
        ebusy[k] = act[k] || (cyc < nok[k] - 1);
      end
    end
  end

  task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s dut%0d got %0h expected %0h at %0t", name, k, got, exp, $time);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("sel",   k, 32'(sel_s[k]),   32'(esel[k]));
      chk("ack",   k, 32'(ack_s[k]),   32'(eack[k]));
      chk("rdata", k, 32'(rdata_s[k]), 32'(erd[k]));
      chk("busy",  k, 32'(busy_s[k]),  32'(ebusy[k]));
      chk("sel_popcount_le1", k, 32'($countones(sel_s[k]) <= 1), 32'd1);
    end
  end

  // One clock; requesters drop a request bit as soon as its ack is seen.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) req_s[k] = req_s[k] & ~ack_s[k];
  endtask

  task automatic wait_ack(input int k, input int budget, output logic [3:0] got);
    got = 4'b0;
    for (int n = 0; n < budget; n++) begin
      tick();
      if (ack_s[k] != 4'b0) begin
        got = ack_s[k];
        return;
      end
    end
    n_checks++;
    $display("FAIL ack_timeout dut%0d got none expected an ack within %0d cycles", k, budget);
  endtask

  logic [3:0] a;
  bit         saw_ack;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    req_s[0] = 4'b0;
    req_s[1] = 4'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: idle
    for (int i = 0; i < 10; i++) tick();
    chk("idle_sel",   0, 32'(sel_s[0]),   32'h0);
    chk("idle_ack",   0, 32'(ack_s[0]),   32'h0);
    chk("idle_busy",  0, 32'(busy_s[0]),  32'h0);
    chk("idle_rdata", 0, 32'(rdata_s[0]), 32'h00);

    // 2: single requesters a..d
    for (int i = 0; i < 4; i++) begin
      req_s[0] = 4'(1 << i);
      tick();
      chk("single_sel", 0, 32'(sel_s[0]), 32'(1 << i));
      wait_ack(0, 6, a);
      chk("single_ack",   0, 32'(a),          32'(1 << i));
      chk("single_rdata", 0, 32'(rdata_s[0]), 32'(MUXV[i]));
      tick();
      chk("single_ack_clr", 0, 32'(ack_s[0]), 32'h0);
      chk("single_sel_clr", 0, 32'(sel_s[0]), 32'h0);
    end

    // 3: all four at once, round-robin order
    req_s[0] = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_ack(0, 8, a);
      chk("rr_ack",   0, 32'(a),          32'(1 << i));
      chk("rr_rdata", 0, 32'(rdata_s[0]), 32'(MUXV[i]));
    end
    tick();

    // 4: move ptr to 2, then wrap-around
    req_s[0] = 4'b0010;
    wait_ack(0, 6, a);
    chk("ptr2_ack", 0, 32'(a), 32'h2);
    tick();
    req_s[0] = 4'b0011;
    wait_ack(0, 8, a);
    chk("wrap_ack0", 0, 32'(a), 32'h1);
    wait_ack(0, 8, a);
    chk("wrap_ack1", 0, 32'(a), 32'h2);
    chk("wrap_rdata", 0, 32'(rdata_s[0]), 32'hbb);
    tick();

    // 5: SETTLE_CYCLES=3
    req_s[1] = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s3_sel", 1, 32'(sel_s[1]), 32'h4);
      chk("s3_ack_early", 1, 32'(ack_s[1]), 32'h0);
    end
    tick();
    chk("s3_ack",   1, 32'(ack_s[1]),   32'h4);
    chk("s3_rdata", 1, 32'(rdata_s[1]), 32'hcc);
    req_s[1] = 4'b0;
    tick();
    tick();
    req_s[1] = 4'b0100;
    tick();
    tick();
    req_s[1] = 4'b0000;
    saw_ack = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ack_s[1] != 4'b0) saw_ack = 1;
    end
    chk("abort_no_ack", 1, 32'(saw_ack),     32'h0);
    chk("abort_rdata",  1, 32'(rdata_s[1]),  32'hcc);
    req_s[1] = 4'b1111;
    wait_ack(1, 8, a);
    chk("abort_ptr3_ack", 1, 32'(a), 32'h8);
    chk("abort_ptr3_rdata", 1, 32'(rdata_s[1]), 32'hdd);
    for (int i = 0; i < 3; i++) begin
      wait_ack(1, 10, a);
      chk("s3_rr_ack", 1, 32'(a), 32'(1 << i));
    end
    tick();

    // 6: reset mid-transaction clears sel without a clock edge
    req_s[0] = 4'b1000;
    tick();
    chk("pre_reset_sel", 0, 32'(sel_s[0]), 32'h8);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_sel", 0, 32'(sel_s[0]), 32'h0);
    req_s[0] = 4'b0;
    req_s[1] = 4'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    req_s[0] = 4'b1111;
    wait_ack(0, 8, a);
    chk("post_reset_ptr0", 0, 32'(a), 32'h1);
    for (int i = 0; i < 3; i++) wait_ack(0, 8, a);
    req_s[0] = 4'b0;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
